// File: rtl/sim_run_controller.sv
// Run controller for CPU simulation and bring-up: sequences the CPU reset, counts RUN cycles,
// detects halt (PC stable), then compares watched registers and reports PASS/FAIL/TIMEOUT.
module sim_run_controller #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned NUM_CHECK      = 4,
  parameter int unsigned RESET_CYCLES   = 2,
  parameter int unsigned HALT_CYCLES    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 600,
  parameter int unsigned CNT_W          = 32
) (
  input  logic                            CLK,
  input  logic                            RESET,
  input  logic [DATA_WIDTH-1:0]           PC_OUT,
  input  logic [NUM_CHECK*DATA_WIDTH-1:0] REG_IN,
  input  logic [NUM_CHECK*DATA_WIDTH-1:0] EXPECT_IN,
  input  logic [NUM_CHECK-1:0]            CHECK_MASK,
  output logic                            CPU_RESET,
  output logic                            RUNNING,
  output logic                            DONE,
  output logic                            PASS,
  output logic                            TIMEOUT,
  output logic [NUM_CHECK-1:0]            FAIL_MASK,
  output logic [CNT_W-1:0]                CYCLE_COUNT
);

  localparam int unsigned RST_W  = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES + 1) : 1;
  localparam int unsigned HALT_W = $clog2(HALT_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_RUN   = 2'd1,
    ST_CHECK = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [RST_W-1:0]      rst_cnt_q, rst_cnt_d;
  logic [HALT_W-1:0]     stable_q, stable_d;
  logic                  first_q, first_d;
  logic [DATA_WIDTH-1:0] prev_pc_q, prev_pc_d;
  logic                  cpu_reset_q, cpu_reset_d;
  logic                  running_q, running_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic                  timeout_q, timeout_d;
  logic [NUM_CHECK-1:0]  fail_mask_q, fail_mask_d;
  logic [CNT_W-1:0]      cycle_q, cycle_d;

  logic [CNT_W-1:0]      cycle_inc;
  logic                  pc_same;
  logic                  halt_hit;
  logic [NUM_CHECK-1:0]  mismatch;

  // Per-channel compare of watched register against expected value
  always_comb begin
    mismatch = '0;
    for (int i = 0; i < int'(NUM_CHECK); i++) begin
      mismatch[i] = (REG_IN[i*DATA_WIDTH +: DATA_WIDTH] != EXPECT_IN[i*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

  assign cycle_inc = (cycle_q == '1) ? cycle_q : cycle_q + CNT_W'(1);
  assign pc_same   = (PC_OUT == prev_pc_q);
  // The first RUN cycle only loads prev_pc, so it can never contribute to a halt
  assign halt_hit  = !first_q && pc_same && (stable_q == HALT_W'(HALT_CYCLES - 1));

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    stable_d    = stable_q;
    first_d     = first_q;
    prev_pc_d   = prev_pc_q;
    cpu_reset_d = cpu_reset_q;
    running_d   = running_q;
    done_d      = done_q;
    pass_d      = pass_q;
    timeout_d   = timeout_q;
    fail_mask_d = fail_mask_q;
    cycle_d     = cycle_q;

    case (state_q)
      ST_RST: begin
        if (rst_cnt_q == RST_W'(RESET_CYCLES - 1)) begin
          state_d     = ST_RUN;
          cpu_reset_d = 1'b0;
          running_d   = 1'b1;
          first_d     = 1'b1;
          stable_d    = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + RST_W'(1);
        end
      end
      ST_RUN: begin
        cycle_d   = cycle_inc;
        prev_pc_d = PC_OUT;
        if (first_q) begin
          first_d  = 1'b0;
          stable_d = '0;
        end else if (pc_same) begin
          stable_d = stable_q + HALT_W'(1);
        end else begin
          stable_d = '0;
        end
        // Halt takes priority over a timeout landing on the same cycle
        if (halt_hit) begin
          state_d   = ST_CHECK;
          running_d = 1'b0;
        end else if (cycle_inc == CNT_W'(TIMEOUT_CYCLES)) begin
          state_d     = ST_FIN;
          running_d   = 1'b0;
          done_d      = 1'b1;
          timeout_d   = 1'b1;
          pass_d      = 1'b0;
          fail_mask_d = '0;
        end
      end
      ST_CHECK: begin
        fail_mask_d = CHECK_MASK & mismatch;
        pass_d      = ~|(CHECK_MASK & mismatch);
        done_d      = 1'b1;
        state_d     = ST_FIN;
      end
      ST_FIN: begin
        state_d = ST_FIN;
      end
      default: begin
        state_d = ST_RST;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_RST;
      rst_cnt_q   <= '0;
      stable_q    <= '0;
      first_q     <= 1'b0;
      prev_pc_q   <= '0;
      cpu_reset_q <= 1'b1;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
      fail_mask_q <= '0;
      cycle_q     <= '0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      stable_q    <= stable_d;
      first_q     <= first_d;
      prev_pc_q   <= prev_pc_d;
      cpu_reset_q <= cpu_reset_d;
      running_q   <= running_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      timeout_q   <= timeout_d;
      fail_mask_q <= fail_mask_d;
      cycle_q     <= cycle_d;
    end
  end

  assign CPU_RESET   = cpu_reset_q;
  assign RUNNING     = running_q;
  assign DONE        = done_q;
  assign PASS        = pass_q;
  assign TIMEOUT     = timeout_q;
  assign FAIL_MASK   = fail_mask_q;
  assign CYCLE_COUNT = cycle_q;

endmodule

// File: tb/tb_sim_run_controller.sv
// Directed bench for sim_run_controller: reset sequencing, halt/check, timeout and mid-run reset.
module tb_sim_run_controller;

  localparam int unsigned DW = 32;
  localparam int unsigned NC = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [DW-1:0]    pc_out;
  logic [NC*DW-1:0] reg_in;
  logic [NC*DW-1:0] expect_in;
  logic [NC-1:0]    check_mask;
  logic             cpu_reset;
  logic             running;
  logic             done;
  logic             pass;
  logic             timeout;
  logic [NC-1:0]    fail_mask;
  logic [31:0]      cycle_count;

  int n_cmp = 0;
  int n_bad = 0;

  sim_run_controller #(
    .DATA_WIDTH(32), .NUM_CHECK(4), .RESET_CYCLES(2),
    .HALT_CYCLES(4), .TIMEOUT_CYCLES(600), .CNT_W(32)
  ) dut (
    .CLK(clk), .RESET(reset), .PC_OUT(pc_out), .REG_IN(reg_in),
    .EXPECT_IN(expect_in), .CHECK_MASK(check_mask), .CPU_RESET(cpu_reset),
    .RUNNING(running), .DONE(done), .PASS(pass), .TIMEOUT(timeout),
    .FAIL_MASK(fail_mask), .CYCLE_COUNT(cycle_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [DW-1:0] r, input logic [DW-1:0] e);
    reg_in[ch*DW +: DW]    = r;
    expect_in[ch*DW +: DW] = e;
  endtask

  // Reset pulse then two sequencing edges; leaves the DUT ready for RUN cycle 1
  task automatic start_run();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; pc_out = '0; reg_in = '0; expect_in = '0; check_mask = '0;
    tick();
    n_cmp++; if (cpu_reset !== 1'b1) begin n_bad++; $display("FAIL rst_cpu_reset got %b exp 1", cpu_reset); end
    n_cmp++; if ({running, done, pass, timeout} !== 4'b0000) begin n_bad++; $display("FAIL rst_flags got %b exp 0000", {running, done, pass, timeout}); end
    n_cmp++; if (fail_mask !== 4'b0000) begin n_bad++; $display("FAIL rst_fail_mask got %b exp 0000", fail_mask); end
    n_cmp++; if (cycle_count !== 32'd0) begin n_bad++; $display("FAIL rst_count got %0d exp 0", cycle_count); end
    reset = 1'b0;
    tick();
    n_cmp++; if ({cpu_reset, running} !== 2'b10) begin n_bad++; $display("FAIL seq_edge1 got %b exp 10", {cpu_reset, running}); end
    tick();
    n_cmp++; if ({cpu_reset, running} !== 2'b01) begin n_bad++; $display("FAIL seq_edge2 got %b exp 01", {cpu_reset, running}); end
  endtask

  // PC trace 0,0,4,8,12,12,12,12,12: halt detected on RUN cycle 9
  task automatic halt_run();
    logic [DW-1:0] pcs [9];
    pcs = '{32'd0, 32'd0, 32'd4, 32'd8, 32'd12, 32'd12, 32'd12, 32'd12, 32'd12};
    start_run();
    for (int k = 0; k < 9; k++) begin
      pc_out = pcs[k];
      tick();
      if (k == 7) begin
        n_cmp++; if (running !== 1'b1) begin n_bad++; $display("FAIL halt_pre_running got %b exp 1", running); end
      end
    end
    n_cmp++; if ({running, done} !== 2'b00) begin n_bad++; $display("FAIL halt_detect got %b exp 00", {running, done}); end
    n_cmp++; if (cycle_count !== 32'd9) begin n_bad++; $display("FAIL halt_count got %0d exp 9", cycle_count); end
    tick();
  endtask

  task automatic test_halt_pass();
    set_ch(0, 32'd5, 32'd5);
    set_ch(1, 32'd1, 32'd2);
    set_ch(2, 32'd7, 32'd7);
    set_ch(3, 32'd0, 32'd0);
    check_mask = 4'b0001;
    halt_run();
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL pass_done got %b exp 1", done); end
    n_cmp++; if (pass !== 1'b1) begin n_bad++; $display("FAIL pass_pass got %b exp 1", pass); end
    n_cmp++; if (fail_mask !== 4'b0000) begin n_bad++; $display("FAIL pass_fail_mask got %b exp 0000", fail_mask); end
    n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL pass_timeout got %b exp 0", timeout); end
    pc_out = 32'd100;
    tick(); tick();
    n_cmp++; if (cycle_count !== 32'd9) begin n_bad++; $display("FAIL pass_count_frozen got %0d exp 9", cycle_count); end
    n_cmp++; if ({done, pass} !== 2'b11) begin n_bad++; $display("FAIL pass_sticky got %b exp 11", {done, pass}); end
  endtask

  task automatic test_halt_fail();
    set_ch(0, 32'd5, 32'd5);
    set_ch(1, 32'd1, 32'd2);
    set_ch(2, 32'd7, 32'd8);
    check_mask = 4'b0101;
    halt_run();
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL fail_done got %b exp 1", done); end
    n_cmp++; if (pass !== 1'b0) begin n_bad++; $display("FAIL fail_pass got %b exp 0", pass); end
    n_cmp++; if (fail_mask !== 4'b0100) begin n_bad++; $display("FAIL fail_fail_mask got %b exp 0100", fail_mask); end
    n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL fail_timeout got %b exp 0", timeout); end
  endtask

  task automatic test_timeout();
    set_ch(2, 32'd7, 32'd8);
    check_mask = 4'b1111;
    start_run();
    for (int k = 1; k <= 600; k++) begin
      pc_out = DW'(k);
      tick();
      if (k == 599) begin
        n_cmp++; if ({running, done} !== 2'b10) begin n_bad++; $display("FAIL to_pre got %b exp 10", {running, done}); end
      end
    end
    n_cmp++; if ({done, timeout, pass, running} !== 4'b1100) begin n_bad++; $display("FAIL to_flags got %b exp 1100", {done, timeout, pass, running}); end
    n_cmp++; if (fail_mask !== 4'b0000) begin n_bad++; $display("FAIL to_fail_mask got %b exp 0000", fail_mask); end
    n_cmp++; if (cycle_count !== 32'd600) begin n_bad++; $display("FAIL to_count got %0d exp 600", cycle_count); end
    tick();
    n_cmp++; if (cycle_count !== 32'd600) begin n_bad++; $display("FAIL to_count_frozen got %0d exp 600", cycle_count); end
  endtask

  // PC distinct through cycle 596 then held: fourth repeat lands on cycle 600
  task automatic test_halt_at_timeout();
    set_ch(2, 32'd8, 32'd8);
    check_mask = 4'b0101;
    start_run();
    for (int k = 1; k <= 600; k++) begin
      pc_out = (k <= 596) ? DW'(k) : 32'd596;
      tick();
    end
    n_cmp++; if ({running, done, timeout} !== 3'b000) begin n_bad++; $display("FAIL edge_detect got %b exp 000", {running, done, timeout}); end
    tick();
    n_cmp++; if ({done, timeout, pass} !== 3'b101) begin n_bad++; $display("FAIL edge_flags got %b exp 101", {done, timeout, pass}); end
    n_cmp++; if (cycle_count !== 32'd600) begin n_bad++; $display("FAIL edge_count got %0d exp 600", cycle_count); end
  endtask

  task automatic test_mid_run_reset();
    check_mask = 4'b0000;
    set_ch(2, 32'd7, 32'd8);
    start_run();
    for (int k = 1; k <= 50; k++) begin
      pc_out = DW'(k * 4);
      tick();
    end
    n_cmp++; if (cycle_count !== 32'd50) begin n_bad++; $display("FAIL mid_count got %0d exp 50", cycle_count); end
    reset = 1'b1;
    tick();
    n_cmp++; if ({cpu_reset, running, done, pass, timeout} !== 5'b10000) begin n_bad++; $display("FAIL mid_reset_flags got %b exp 10000", {cpu_reset, running, done, pass, timeout}); end
    n_cmp++; if (cycle_count !== 32'd0) begin n_bad++; $display("FAIL mid_reset_count got %0d exp 0", cycle_count); end
    // Constant PC: cycle 1 loads, cycles 2..5 are repeats 1..4
    pc_out = 32'd3;
    start_run();
    for (int k = 1; k <= 5; k++) tick();
    tick();
    n_cmp++; if ({done, pass, timeout} !== 3'b110) begin n_bad++; $display("FAIL mid_rerun_flags got %b exp 110", {done, pass, timeout}); end
    n_cmp++; if (cycle_count !== 32'd5) begin n_bad++; $display("FAIL mid_rerun_count got %0d exp 5", cycle_count); end
  endtask

  initial begin
    test_reset();
    test_halt_pass();
    test_halt_fail();
    test_timeout();
    test_halt_at_timeout();
    test_mid_run_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
